// File: rtl/rtx_range_marker_if.sv
// Mark-request, ack/clear inputs and bitmap/status outputs of the retransmission range marker.
// The master modport is the requester/scheduler side; the slave modport is the marker itself.
interface rtx_range_marker_if #(
    parameter int WIN_SIZE   = 128,
    parameter int WIN_SIZE_W = $clog2(WIN_SIZE),
    parameter int SEQ_W      = 32
);
    logic                  req_valid;
    logic                  req_ready;
    logic [SEQ_W-1:0]      rtx_start;
    logic [SEQ_W-1:0]      rtx_end;
    logic [WIN_SIZE-1:0]   acked_wnd_in;
    logic                  rtx_clr_valid;
    logic [WIN_SIZE_W-1:0] rtx_clr_idx;
    logic [WIN_SIZE-1:0]   rtx_wnd_out;
    logic                  busy;
    logic                  done;
    logic [WIN_SIZE_W:0]   mark_cnt;
    logic                  range_err;

    modport master (
        output req_valid, rtx_start, rtx_end, acked_wnd_in, rtx_clr_valid, rtx_clr_idx,
        input  req_ready, rtx_wnd_out, busy, done, mark_cnt, range_err
    );

    modport slave (
        input  req_valid, rtx_start, rtx_end, acked_wnd_in, rtx_clr_valid, rtx_clr_idx,
        output req_ready, rtx_wnd_out, busy, done, mark_cnt, range_err
    );
endinterface

// File: rtl/rtx_range_marker.sv
// Walks [rtx_start, rtx_end) one seq per cycle, setting unacked bits in a circular retransmit bitmap.
// Latency: L+1 cycles from accept to done (1 cycle for empty or oversize ranges); ack/clear act next edge.
// Backpressure: req_ready low while walking and in the done cycle; requests are never queued.
module rtx_range_marker #(
    parameter int WIN_SIZE   = 128,
    parameter int WIN_SIZE_W = $clog2(WIN_SIZE),
    parameter int SEQ_W      = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    rtx_range_marker_if.slave bus
);
    typedef enum logic [1:0] {IDLE, MARK, DONE} state_t;

    state_t                state, state_nxt;
    logic [SEQ_W-1:0]      cur, cur_nxt, end_r, end_nxt, cur_inc, req_len;
    logic [WIN_SIZE-1:0]   rtx_wnd, set_mask, clr_mask;
    logic [WIN_SIZE_W:0]   mark_cnt, mark_cnt_nxt;
    logic                  range_err, range_err_nxt;
    logic [WIN_SIZE_W-1:0] cur_idx;

    assign cur_idx = cur[WIN_SIZE_W-1:0];
    assign cur_inc = cur + SEQ_W'(1);
    assign req_len = bus.rtx_end - bus.rtx_start;

    always_comb begin
        state_nxt     = state;
        cur_nxt       = cur;
        end_nxt       = end_r;
        mark_cnt_nxt  = mark_cnt;
        range_err_nxt = range_err;
        set_mask      = '0;
        case (state)
            IDLE: begin
                if (bus.req_valid) begin
                    cur_nxt       = bus.rtx_start;
                    end_nxt       = bus.rtx_end;
                    mark_cnt_nxt  = '0;
                    range_err_nxt = 1'b0;
                    if (req_len == '0) begin
                        state_nxt = DONE;
                    end else if (req_len > SEQ_W'(WIN_SIZE)) begin
                        range_err_nxt = 1'b1;
                        state_nxt     = DONE;
                    end else begin
                        state_nxt = MARK;
                    end
                end
            end
            MARK: begin
                // An ack arriving this cycle suppresses the set, so acked packets never re-enter the bitmap.
                if (!bus.acked_wnd_in[cur_idx]) begin
                    set_mask[cur_idx] = 1'b1;
                    if (!rtx_wnd[cur_idx]) begin
                        mark_cnt_nxt = mark_cnt + (WIN_SIZE_W+1)'(1);
                    end
                end
                cur_nxt = cur_inc;
                if (cur_inc == end_r) begin
                    state_nxt = DONE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        clr_mask = '0;
        if (bus.rtx_clr_valid) begin
            clr_mask[bus.rtx_clr_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cur       <= '0;
            end_r     <= '0;
            mark_cnt  <= '0;
            range_err <= 1'b0;
            rtx_wnd   <= '0;
        end else begin
            state     <= state_nxt;
            cur       <= cur_nxt;
            end_r     <= end_nxt;
            mark_cnt  <= mark_cnt_nxt;
            range_err <= range_err_nxt;
            // Set is ORed last so it wins over a same-cycle scheduler clear.
            rtx_wnd   <= (rtx_wnd & ~bus.acked_wnd_in & ~clr_mask) | set_mask;
        end
    end

    assign bus.req_ready   = (state == IDLE);
    assign bus.busy        = (state == MARK);
    assign bus.done        = (state == DONE);
    assign bus.rtx_wnd_out = rtx_wnd;
    assign bus.mark_cnt    = mark_cnt;
    assign bus.range_err   = range_err;
endmodule

// File: tb/tb_rtx_range_marker.sv
// Randomized and directed bench for rtx_range_marker against a time-based behavioural model.
module tb_rtx_range_marker;
    localparam int W  = 128;
    localparam int WW = 7;
    localparam int SW = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_chk = 0;
    int   n_err = 0;
    bit   chk_en = 1'b0;

    always #5 clk = ~clk;

    rtx_range_marker_if #(.WIN_SIZE(W), .WIN_SIZE_W(WW), .SEQ_W(SW)) bus ();

    rtx_range_marker #(.WIN_SIZE(W), .WIN_SIZE_W(WW), .SEQ_W(SW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Model: a request accepted at the end of cycle a marks seq start+k during cycle a+1+k.
    bit [W-1:0]  m_wnd = '0;
    int          m_cnt = 0;
    bit          m_err = 1'b0;
    bit          m_act = 1'b0;
    bit          m_walk = 1'b0;
    longint      m_a = 0, m_len = 0, m_done_c = 0, cyc = 0;
    logic [31:0] m_start = '0;

    function automatic bit m_ready();
        return !(m_act && cyc > m_a && cyc <= m_done_c);
    endfunction

    function automatic bit m_busy();
        return m_act && m_walk && cyc > m_a && cyc <= m_a + m_len;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        bit [W-1:0]  set_v, clr_v;
        logic [31:0] seq, len;
        bit          acc;
        if (!rst_n) begin
            m_wnd = '0; m_cnt = 0; m_err = 1'b0; m_act = 1'b0; m_walk = 1'b0;
        end else begin
            set_v = '0;
            clr_v = '0;
            if (m_busy()) begin
                seq = m_start + 32'(cyc - m_a - 1);
                if (!bus.acked_wnd_in[seq % W]) begin
                    if (!m_wnd[seq % W]) m_cnt++;
                    set_v[seq % W] = 1'b1;
                end
            end
            if (bus.rtx_clr_valid) clr_v[bus.rtx_clr_idx] = 1'b1;
            acc = m_ready() && bus.req_valid;
            m_wnd = (m_wnd & ~bus.acked_wnd_in & ~clr_v) | set_v;
            if (acc) begin
                len      = bus.rtx_end - bus.rtx_start;
                m_act    = 1'b1;
                m_a      = cyc;
                m_start  = bus.rtx_start;
                m_len    = longint'(len);
                m_cnt    = 0;
                m_err    = (m_len > W);
                m_walk   = (m_len != 0) && !m_err;
                m_done_c = m_walk ? cyc + m_len + 1 : cyc + 1;
            end
            cyc++;
        end
    end

    always @(negedge clk) begin
        if (chk_en && rst_n) begin
            chk("wnd",   bus.rtx_wnd_out, m_wnd);
            chk("busy",  W'(bus.busy), W'(m_busy()));
            chk("done",  W'(bus.done), W'(m_act && cyc == m_done_c));
            chk("ready", W'(bus.req_ready), W'(m_ready()));
            chk("cnt",   W'(bus.mark_cnt), W'(m_cnt));
            chk("err",   W'(bus.range_err), W'(m_err));
        end
    end

    function automatic logic [W-1:0] bits4(input int a, input int b, input int c, input int d);
        logic [W-1:0] v;
        v = '0;
        v[a] = 1'b1; v[b] = 1'b1; v[c] = 1'b1; v[d] = 1'b1;
        return v;
    endfunction

    task automatic idle_inputs();
        bus.req_valid = 1'b0; bus.rtx_start = '0; bus.rtx_end = '0;
        bus.acked_wnd_in = '0; bus.rtx_clr_valid = 1'b0; bus.rtx_clr_idx = '0;
    endtask

    task automatic wipe();
        @(negedge clk); bus.acked_wnd_in = '1;
        @(negedge clk); bus.acked_wnd_in = '0;
    endtask

    // Returns the cycle (1 = first cycle after the accept edge) in which done is seen.
    task automatic do_req(input logic [31:0] s, input logic [31:0] e, output int k);
        int n;
        n = 0;
        @(negedge clk);
        while (!bus.req_ready && n < 300) begin @(negedge clk); n++; end
        if (n >= 300) chk("ready_timeout", 0, 1);
        bus.req_valid = 1'b1; bus.rtx_start = s; bus.rtx_end = e;
        @(posedge clk);
        k = 1;
        @(negedge clk);
        bus.req_valid = 1'b0;
        while (!bus.done && k < 300) begin @(negedge clk); k++; end
        if (k >= 300) chk("done_timeout", 0, 1);
    endtask

    initial begin
        int k;
        logic [W-1:0] v;
        idle_inputs();
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;
        chk("rst_wnd",   bus.rtx_wnd_out, '0);
        chk("rst_ready", W'(bus.req_ready), 1);
        chk("rst_busy",  W'(bus.busy), 0);
        chk("rst_cnt",   W'(bus.mark_cnt), 0);
        chk_en = 1'b1;

        do_req(32'd10, 32'd14, k);
        chk("basic_done_cyc", k, 5);
        chk("basic_wnd", bus.rtx_wnd_out, bits4(10, 11, 12, 13));
        chk("basic_cnt", W'(bus.mark_cnt), 4);
        chk("basic_err", W'(bus.range_err), 0);

        wipe();
        v = '0; v[127] = 1'b1;
        bus.acked_wnd_in = v;
        do_req(32'd126, 32'd131, k);
        chk("skip_wnd", bus.rtx_wnd_out, bits4(126, 0, 1, 2));
        chk("skip_cnt", W'(bus.mark_cnt), 4);
        bus.acked_wnd_in = '0;

        wipe();
        do_req(32'hFFFF_FFFE, 32'h0000_0002, k);
        chk("swrap_done_cyc", k, 5);
        chk("swrap_wnd", bus.rtx_wnd_out, bits4(126, 127, 0, 1));
        chk("swrap_cnt", W'(bus.mark_cnt), 4);

        wipe();
        do_req(32'd0, 32'd200, k);
        chk("err_done_cyc", k, 1);
        chk("err_flag", W'(bus.range_err), 1);
        chk("err_wnd", bus.rtx_wnd_out, '0);
        do_req(32'd50, 32'd50, k);
        chk("empty_done_cyc", k, 1);
        chk("empty_cnt", W'(bus.mark_cnt), 0);
        chk("empty_err", W'(bus.range_err), 0);

        // Contention: walk 20..24, same-cycle clear of 22, late clear of 20, ack on 23, ignored request.
        @(negedge clk);
        bus.req_valid = 1'b1; bus.rtx_start = 32'd20; bus.rtx_end = 32'd25;
        @(posedge clk);
        for (int c = 1; c <= 7; c++) begin
            @(negedge clk);
            bus.req_valid = (c >= 2 && c <= 4);
            bus.rtx_start = 32'd100; bus.rtx_end = 32'd102;
            v = '0; if (c >= 2 && c <= 4) v[23] = 1'b1;
            bus.acked_wnd_in = v;
            bus.rtx_clr_valid = (c == 3 || c == 5);
            bus.rtx_clr_idx = (c == 3) ? 7'd22 : 7'd20;
            if (c == 6) chk("cont_done", W'(bus.done), 1);
        end
        idle_inputs();
        v = '0; v[21] = 1'b1; v[22] = 1'b1; v[24] = 1'b1;
        chk("cont_wnd", bus.rtx_wnd_out, v);
        chk("cont_cnt", W'(bus.mark_cnt), 4);

        // Reset in cycle 3 of the walk 0..10.
        @(negedge clk);
        bus.req_valid = 1'b1; bus.rtx_start = 32'd0; bus.rtx_end = 32'd10;
        @(posedge clk);
        @(negedge clk); bus.req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_wnd",   bus.rtx_wnd_out, '0);
        chk("mid_rst_busy",  W'(bus.busy), 0);
        chk("mid_rst_ready", W'(bus.req_ready), 1);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            chk("mid_rst_no_done", W'(bus.done), 0);
        end
        chk("mid_rst_wnd_after", bus.rtx_wnd_out, '0);

        // Random traffic, checked every cycle by the model.
        for (int c = 0; c < 2500; c++) begin
            logic [31:0] s, len;
            @(negedge clk);
            s   = ($urandom % 2 == 0) ? $urandom : 32'hFFFF_FF80 + $urandom_range(0, 127);
            len = ($urandom % 8 == 0) ? $urandom_range(129, 400) : $urandom_range(0, 128);
            bus.req_valid = ($urandom % 4 == 0);
            bus.rtx_start = s;
            bus.rtx_end   = s + len;
            v = '0;
            if ($urandom % 200 == 0) v = {$urandom, $urandom, $urandom, $urandom};
            else if ($urandom % 6 == 0) v[$urandom_range(0, W-1)] = 1'b1;
            bus.acked_wnd_in  = v;
            bus.rtx_clr_valid = ($urandom % 5 == 0);
            bus.rtx_clr_idx   = 7'($urandom_range(0, W-1));
        end
        idle_inputs();
        repeat (5) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end
endmodule
